id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline stage of the pipelined RISC-V core. Captures the main decoder's control outputs together with register-file operands, immediate, PC and register specifiers into the EX-stage register on each clock. Detects load-use hazards against the instruction currently in EX, stalls fetch/decode and injects a bubble. Supports an EX flush for taken branches, a global hold for multi-cycle memory, and a saturating bubble counter for performance analysis.

## Interface
Parameters:
- XLEN, 32, datapath width for operands, immediate and PC.
- CNTW, 32, width of the bubble counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_d  in  1  ID holds a real instruction.
- resultsrc_d, memwrite_d, alusrc_d, regwrite_d, branch_d  in  1 each  decoder control outputs.
- aluop_d  in  2  decoder ALU op class.
- funct3_d  in  3  instr[14:12].
- funct7b5_d  in  1  instr[30].
- rs1_d, rs2_d, rd_d  in  5 each  register specifiers.
- rd1_d, rd2_d  in  XLEN  register-file read data.
- imm_d  in  XLEN  extended immediate.
- pc_d  in  XLEN  instruction PC.
- flush_e  in  1  branch resolved taken; kill the instruction entering EX.
- hold_e  in  1  downstream stall; freeze the EX register.
- valid_e, resultsrc_e, memwrite_e, alusrc_e, regwrite_e, branch_e  out  1 each  registered copies.
- aluop_e  out  2; funct3_e  out  3; funct7b5_e  out  1.
- rs1_e, rs2_e, rd_e  out  5 each.
- rd1_e, rd2_e, imm_e, pc_e  out  XLEN each.
- stall_d  out  1  hold PC and IF/ID register this cycle.
- bubble_cnt  out  CNTW  count of bubbles injected by load-use hazards.

## Operation
- Hazard, combinational: load_use = valid_d & valid_e & resultsrc_e & regwrite_e & (rd_e != 0) & ((rd_e == rs1_d) | (use_rs2 & (rd_e == rs2_d))).
- use_rs2 = ~alusrc_d | memwrite_d. This is true for R-type, branch and store, and false for load.
- stall_d = hold_e | (load_use & ~flush_e).
- EX register update, in priority order:
  1. rst: every output register clears to 0, including bubble_cnt.
  2. hold_e: all EX registers keep their value; bubble_cnt unchanged.
  3. flush_e: load a bubble (all control bits, valid_e, rs/rd fields cleared to 0; data fields don't-care, cleared to 0).
  4. load_use: load a bubble; bubble_cnt increments by 1, saturating at 2^CNTW−1.
  5. Otherwise: load all _d inputs. valid_e = valid_d.
- A bubble or an invalid instruction (valid_e=0) must never assert memwrite_e, regwrite_e or branch_e. When valid_d=0, all control bits are loaded as 0.
- flush_e together with load_use: flush wins, stall_d=0, and bubble_cnt is not incremented.
- hold_e together with flush_e: hold wins. Upstream keeps flush_e asserted until hold_e drops.

## Timing
- Latency of 1 cycle from ID inputs to EX outputs.
- stall_d is combinational from current ID inputs and EX-register state, valid in the same cycle.
- A load-use sequence costs exactly 1 bubble. The cycle after the bubble, the load has left EX, load_use=0, and the dependent instruction enters EX.
- Reset mid-operation: a pending hazard or flush is discarded. On the first cycle after rst deasserts, stall_d=0 unless a new hazard is present; since valid_e=0, no hazard is possible that cycle.
- Reset values: all outputs 0, and stall_d=0 during reset with hold_e=0.

## Test plan
- Reset: assert rst with arbitrary inputs. After the edge, all _e outputs=0, bubble_cnt=0, stall_d=0.
- Pass-through: add x3,x1,x2 (regwrite_d=1, aluop_d=2'b10, rd1_d=0x11, rd2_d=0x22, pc_d=0x40), no stall. Next cycle: rd_e=3, rd1_e=0x11, rd2_e=0x22, pc_e=0x40, valid_e=1.
- Load-use on rs1: lw x5 in EX; add x6,x5,x1 in ID. Required: stall_d=1; next edge valid_e=0, regwrite_e=0, bubble_cnt=1; following edge rd_e=6.
- rs2 filtering: lw x5 in EX.
  - sw x5,0(x7) in ID (rs2=5, memwrite_d=1): stall_d=1.
  - lw x8,0(x9) in ID with rs2 field=5 (alusrc_d=1, memwrite_d=0): stall_d=0.
  - lw x0 in EX: no stall for any consumer.
- Priority: load-use and flush_e in the same cycle produce a bubble, stall_d=0 and bubble_cnt unchanged. With hold_e=1 plus flush_e, the EX outputs stay frozen and stall_d=1. Release hold_e and the bubble is loaded.
- Saturation: with CNTW=4, inject 17 load-use hazards. bubble_cnt must hold at 15.

Source files
------------

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection, flush, hold and bubble counter
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_d,
  input  logic            resultsrc_d,
  input  logic            memwrite_d,
  input  logic            alusrc_d,
  input  logic            regwrite_d,
  input  logic            branch_d,
  input  logic [1:0]      aluop_d,
  input  logic [2:0]      funct3_d,
  input  logic            funct7b5_d,
  input  logic [4:0]      rs1_d,
  input  logic [4:0]      rs2_d,
  input  logic [4:0]      rd_d,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic [XLEN-1:0] imm_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic            flush_e,
  input  logic            hold_e,
  output logic            valid_e,
  output logic            resultsrc_e,
  output logic            memwrite_e,
  output logic            alusrc_e,
  output logic            regwrite_e,
  output logic            branch_e,
  output logic [1:0]      aluop_e,
  output logic [2:0]      funct3_e,
  output logic            funct7b5_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] imm_e,
  output logic [XLEN-1:0] pc_e,
  output logic            stall_d,
  output logic [CNTW-1:0] bubble_cnt
);

  logic use_rs2;
  logic load_use;
  logic bubble;

  // Loads use rs2 bits as immediate, so only R-type/branch/store really read rs2.
  assign use_rs2  = ~alusrc_d | memwrite_d;
  assign load_use = valid_d & valid_e & resultsrc_e & regwrite_e & (rd_e != 5'd0) &
                    ((rd_e == rs1_d) | (use_rs2 & (rd_e == rs2_d)));
  assign stall_d  = hold_e | (load_use & ~flush_e);
  assign bubble   = flush_e | load_use;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_e     <= 1'b0;
      resultsrc_e <= 1'b0;
      memwrite_e  <= 1'b0;
      alusrc_e    <= 1'b0;
      regwrite_e  <= 1'b0;
      branch_e    <= 1'b0;
      aluop_e     <= 2'b00;
      funct3_e    <= 3'b000;
      funct7b5_e  <= 1'b0;
      rs1_e       <= 5'd0;
      rs2_e       <= 5'd0;
      rd_e        <= 5'd0;
      rd1_e       <= '0;
      rd2_e       <= '0;
      imm_e       <= '0;
      pc_e        <= '0;
      bubble_cnt  <= '0;
    end else if (!hold_e) begin
      if (bubble) begin
        valid_e     <= 1'b0;
        resultsrc_e <= 1'b0;
        memwrite_e  <= 1'b0;
        alusrc_e    <= 1'b0;
        regwrite_e  <= 1'b0;
        branch_e    <= 1'b0;
        aluop_e     <= 2'b00;
        funct3_e    <= 3'b000;
        funct7b5_e  <= 1'b0;
        rs1_e       <= 5'd0;
        rs2_e       <= 5'd0;
        rd_e        <= 5'd0;
        rd1_e       <= '0;
        rd2_e       <= '0;
        imm_e       <= '0;
        pc_e        <= '0;
      end else begin
        // Control is qualified by valid_d so an empty slot can never write state.
        valid_e     <= valid_d;
        resultsrc_e <= valid_d & resultsrc_d;
        memwrite_e  <= valid_d & memwrite_d;
        alusrc_e    <= valid_d & alusrc_d;
        regwrite_e  <= valid_d & regwrite_d;
        branch_e    <= valid_d & branch_d;
        aluop_e     <= valid_d ? aluop_d : 2'b00;
        funct3_e    <= funct3_d;
        funct7b5_e  <= funct7b5_d;
        rs1_e       <= rs1_d;
        rs2_e       <= rs2_d;
        rd_e        <= rd_d;
        rd1_e       <= rd1_d;
        rd2_e       <= rd2_d;
        imm_e       <= imm_d;
        pc_e        <= pc_d;
      end
      if (load_use && !flush_e && (bubble_cnt != {CNTW{1'b1}}))
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int CNTW = 4;

  logic clk = 1'b0;
  logic rst;
  logic valid_d, resultsrc_d, memwrite_d, alusrc_d, regwrite_d, branch_d;
  logic [1:0] aluop_d;
  logic [2:0] funct3_d;
  logic funct7b5_d;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic [XLEN-1:0] rd1_d, rd2_d, imm_d, pc_d;
  logic flush_e, hold_e;
  logic valid_e, resultsrc_e, memwrite_e, alusrc_e, regwrite_e, branch_e;
  logic [1:0] aluop_e;
  logic [2:0] funct3_e;
  logic funct7b5_e;
  logic [4:0] rs1_e, rs2_e, rd_e;
  logic [XLEN-1:0] rd1_e, rd2_e, imm_e, pc_e;
  logic stall_d;
  logic [CNTW-1:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .valid_d(valid_d), .resultsrc_d(resultsrc_d),
    .memwrite_d(memwrite_d), .alusrc_d(alusrc_d), .regwrite_d(regwrite_d),
    .branch_d(branch_d), .aluop_d(aluop_d), .funct3_d(funct3_d),
    .funct7b5_d(funct7b5_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .pc_d(pc_d),
    .flush_e(flush_e), .hold_e(hold_e), .valid_e(valid_e),
    .resultsrc_e(resultsrc_e), .memwrite_e(memwrite_e), .alusrc_e(alusrc_e),
    .regwrite_e(regwrite_e), .branch_e(branch_e), .aluop_e(aluop_e),
    .funct3_e(funct3_e), .funct7b5_e(funct7b5_e), .rs1_e(rs1_e),
    .rs2_e(rs2_e), .rd_e(rd_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .imm_e(imm_e), .pc_e(pc_e), .stall_d(stall_d), .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive an ID instruction: v, resultsrc, memwrite, alusrc, regwrite, branch, rs1, rs2, rd
  task automatic id(input logic v, input logic rs, input logic mw, input logic as,
                    input logic rw, input logic br, input logic [4:0] r1,
                    input logic [4:0] r2, input logic [4:0] rd);
    valid_d = v; resultsrc_d = rs; memwrite_d = mw; alusrc_d = as;
    regwrite_d = rw; branch_d = br; rs1_d = r1; rs2_d = r2; rd_d = rd;
    aluop_d = (as || mw) ? 2'b00 : 2'b10;
    funct3_d = 3'b010; funct7b5_d = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush_e = 1'b0; hold_e = 1'b0;
    rd1_d = 32'hdead_beef; rd2_d = 32'h1234_5678; imm_d = 32'h55; pc_d = 32'h100;
    id(1, 1, 1, 1, 1, 1, 5'd7, 5'd8, 5'd9);
    step();
    step();
    chk("rst_valid_e", valid_e, 0);
    chk("rst_memwrite_e", memwrite_e, 0);
    chk("rst_regwrite_e", regwrite_e, 0);
    chk("rst_rd_e", rd_e, 0);
    chk("rst_rd1_e", rd1_e, 0);
    chk("rst_pc_e", pc_e, 0);
    chk("rst_bubble_cnt", bubble_cnt, 0);
    chk("rst_stall_d", stall_d, 0);

    // add x3,x1,x2 passes straight through
    rst = 1'b0;
    rd1_d = 32'h11; rd2_d = 32'h22; pc_d = 32'h40;
    id(1, 0, 0, 0, 1, 0, 5'd1, 5'd2, 5'd3);
    chk("pass_stall_d", stall_d, 0);
    step();
    chk("pass_rd_e", rd_e, 3);
    chk("pass_rd1_e", rd1_e, 32'h11);
    chk("pass_rd2_e", rd2_e, 32'h22);
    chk("pass_pc_e", pc_e, 32'h40);
    chk("pass_valid_e", valid_e, 1);
    chk("pass_regwrite_e", regwrite_e, 1);
    chk("pass_aluop_e", aluop_e, 2'b10);

    // lw x5 then add x6,x5,x1
    pc_d = 32'h44;
    id(1, 1, 0, 1, 1, 0, 5'd1, 5'd0, 5'd5);
    step();
    pc_d = 32'h48;
    id(1, 0, 0, 0, 1, 0, 5'd5, 5'd1, 5'd6);
    chk("lu_rs1_stall_d", stall_d, 1);
    step();
    chk("lu_bubble_valid_e", valid_e, 0);
    chk("lu_bubble_regwrite_e", regwrite_e, 0);
    chk("lu_bubble_cnt", bubble_cnt, 1);
    chk("lu_after_bubble_stall_d", stall_d, 0);
    step();
    chk("lu_dep_rd_e", rd_e, 6);
    chk("lu_dep_valid_e", valid_e, 1);
    chk("lu_dep_pc_e", pc_e, 32'h48);

    // rs2 filtering with lw x5 in EX
    id(1, 1, 0, 1, 1, 0, 5'd1, 5'd0, 5'd5);
    step();
    id(1, 0, 1, 1, 0, 0, 5'd7, 5'd5, 5'd0);
    chk("sw_rs2_stall_d", stall_d, 1);
    id(1, 1, 0, 1, 1, 0, 5'd9, 5'd5, 5'd8);
    chk("lw_rs2_nostall_d", stall_d, 0);
    id(1, 0, 0, 0, 1, 0, 5'd1, 5'd5, 5'd6);
    chk("rtype_rs2_stall_d", stall_d, 1);
    id(0, 0, 0, 0, 1, 0, 5'd5, 5'd5, 5'd6);
    chk("invalid_id_nostall_d", stall_d, 0);

    // flush beats load-use: bubble, no stall, counter unchanged
    id(1, 0, 0, 0, 1, 0, 5'd5, 5'd1, 5'd6);
    flush_e = 1'b1;
    #1;
    chk("flush_lu_stall_d", stall_d, 0);
    step();
    flush_e = 1'b0;
    chk("flush_lu_valid_e", valid_e, 0);
    chk("flush_lu_rd_e", rd_e, 0);
    chk("flush_lu_bubble_cnt", bubble_cnt, 1);

    // lw x0 never stalls a consumer
    id(1, 1, 0, 1, 1, 0, 5'd1, 5'd0, 5'd0);
    step();
    id(1, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd6);
    chk("lw_x0_stall_d", stall_d, 0);

    // hold + flush: frozen, then bubble after hold drops
    rd1_d = 32'h11; pc_d = 32'h40;
    id(1, 0, 0, 0, 1, 0, 5'd1, 5'd2, 5'd3);
    step();
    chk("hold_pre_rd_e", rd_e, 3);
    pc_d = 32'h80;
    id(1, 0, 1, 1, 0, 0, 5'd3, 5'd4, 5'd9);
    hold_e = 1'b1; flush_e = 1'b1;
    #1;
    chk("hold_stall_d", stall_d, 1);
    step();
    step();
    chk("hold_rd_e", rd_e, 3);
    chk("hold_pc_e", pc_e, 32'h40);
    chk("hold_valid_e", valid_e, 1);
    hold_e = 1'b0;
    #1;
    chk("hold_release_stall_d", stall_d, 0);
    step();
    flush_e = 1'b0;
    chk("flush_after_hold_valid_e", valid_e, 0);
    chk("flush_after_hold_pc_e", pc_e, 0);
    chk("flush_after_hold_memwrite_e", memwrite_e, 0);

    // invalid ID slot loads no control bits
    id(0, 1, 1, 1, 1, 1, 5'd1, 5'd2, 5'd3);
    step();
    chk("inv_memwrite_e", memwrite_e, 0);
    chk("inv_regwrite_e", regwrite_e, 0);
    chk("inv_branch_e", branch_e, 0);

    // reset mid-hazard discards it
    id(1, 1, 0, 1, 1, 0, 5'd1, 5'd0, 5'd5);
    step();
    id(1, 0, 0, 0, 1, 0, 5'd5, 5'd1, 5'd6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midrst_valid_e", valid_e, 0);
    chk("midrst_bubble_cnt", bubble_cnt, 0);
    chk("midrst_stall_d", stall_d, 0);

    // 17 load-use hazards saturate a 4-bit counter at 15
    for (int i = 0; i < 17; i++) begin
      id(1, 1, 0, 1, 1, 0, 5'd1, 5'd0, 5'd5);
      step();
      id(1, 0, 0, 0, 1, 0, 5'd5, 5'd1, 5'd6);
      step();
      if (i == 14) chk("sat_cnt_at_15", bubble_cnt, 15);
    end
    chk("sat_cnt_held", bubble_cnt, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
